memory_stage: RTL
=================

Name: memory_stage

Overview:
- Memory (MEM) stage of the 5-stage RV64 pipeline. Sits between execute and writeback.
- Consumes the execute-stage bundle `execute_data_t` and produces the registered memory-stage bundle `memory_data_t`.
- Performs LD/SD via a two-phase data-bus handshake (address phase, then data phase) and stalls the upstream stages while a bus transaction is in flight.

Parameters:
- MMIO_BIT, 31: address bit that separates memory from MMIO; a memory op with this bit equal to 0 sets `skip`.
- ALIGN_CHECK, 1: when 1, a misaligned LD/SD (result[2:0] != 0) is not issued to the bus.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute bundle valid
- in  in  $bits(execute_data_t)  execute bundle: pc, instruction, j_addr, memdata, result, ctl
- in_ready  out  1  stage can accept `in` this cycle
- out_valid  out  1  `out` holds a valid instruction
- out  out  $bits(memory_data_t)  registered bundle to writeback
- out_ready  in  1  writeback accepts `out`
- dreq_valid  out  1  data-bus request valid
- dreq_addr  out  64  byte address
- dreq_size  out  3  MSIZE8 = 3'b011 (LD/SD only)
- dreq_strobe  out  8  8'h00 for a read, 8'hFF for a write
- dreq_data  out  64  store data
- dresp_addr_ok  in  1  address phase accepted
- dresp_data_ok  in  1  data phase complete
- dresp_data  in  64  load data, valid when dresp_data_ok = 1
- misalign  out  1  one-cycle pulse: a misaligned memory op was suppressed

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; out_valid = 0; out = '0.
  - dreq_valid = 0; misalign = 0.
  - A transaction in flight is abandoned; dresp_* are ignored until reset is released.
- FSM states: IDLE, ADDR, DATA.
- Ready and accept:
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Retire = out_valid && out_ready, which clears out_valid unless a new result is loaded in the same cycle.
- Non-memory op (ctl.memread = 0 and ctl.memwrite = 0):
  - Registered at the accept edge; 1-cycle latency.
  - out.regdata = in.result.
  - out.pc, op, instruction, jump, regwrite and dst are copied from `in`.
  - out.skip = 0; out.address = 0.
- Memory op on accept:
  - Capture `in` into a holding register; state goes IDLE to ADDR.
  - From the next cycle, dreq_valid = 1, driven from the holding register:
    - dreq_addr = result.
    - dreq_data = memdata.
    - dreq_strobe = 8'hFF if memwrite, else 8'h00.
    - dreq_size = 3'b011.
  - All dreq_* fields stay stable while in ADDR.
- ADDR state:
  - dresp_addr_ok = 1: drop dreq_valid next cycle; go to DATA.
  - dresp_addr_ok = 1 and dresp_data_ok = 1 in the same cycle: complete immediately; skip DATA.
- DATA state:
  - Wait for dresp_data_ok. dresp_data_ok arriving before addr_ok is ignored.
- Completion (edge at which data_ok is sampled):
  - out_valid = 1; state = IDLE.
  - out.regdata = dresp_data for LD, 0 for SD.
  - out.regwrite = in.ctl.regwrite && memread (SD never writes).
  - out.address = result; out.skip = (result[MMIO_BIT] == 0).
- Latency:
  - LD/SD takes 1 cycle + cycles until addr_ok + cycles until data_ok.
  - Minimum 2 cycles accept-to-out_valid (addr_ok and data_ok in the first request cycle).
- Misaligned op (ALIGN_CHECK = 1, memory op, result[2:0] != 0):
  - No bus request; treated as a non-memory op, 1 cycle.
  - out.regwrite = 0; misalign pulses for 1 cycle.
- Output backpressure: out is held stable while out_valid && !out_ready. Because in_ready = 0 in that condition, no new accept can occur.
- Bubble: in_valid = 0 with writeback ready gives out_valid = 0 next cycle.
- Width rule: LD returns the full 64-bit word, with no sign or zero extension. Sub-word ops are out of scope.

Decomposition:
- Shared package `pipes`, which already holds `execute_data_t`, `memory_data_t` and `decode_op_t`. Add to it:
  - `mem_state_t` enum {IDLE, ADDR, DATA}.
  - Constant MSIZE8 = 3'b011.
  - Constants STROBE_RD = 8'h00 and STROBE_WR = 8'hFF.
- Bus request/response structs (`dbus_req_t`, `dbus_resp_t`) belong in `common`.
- One sub-module, `dbus_ctrl`:
  - Contains the FSM, request hold and response capture.
  - Interface: start, addr, data, write in; done, rdata out.
  - The top level handles the bundle mux and the output register.

Test Plan:
- ADDI, result = 64'h5, out_ready = 1 -> out_valid one cycle later, regdata = 5, skip = 0, dreq_valid never asserted.
- LD, result = 64'h8000_1000; bus gives addr_ok in cycle 1 and data_ok = 1 with data 64'hDEAD_BEEF_0123_4567 in cycle 3 -> in_ready = 0 for 3 cycles, regdata = 64'hDEAD_BEEF_0123_4567, skip = 0, address = 64'h8000_1000.
- SD, result = 64'h4000_0008, memdata = 64'h1234; addr_ok and data_ok both in first request cycle -> strobe = 8'hFF, dreq_data = 64'h1234, out_valid 2 cycles after accept, regwrite = 0, skip = 1.
- LD with result = 64'h8000_0004 -> no dreq_valid, misalign pulse, out.regwrite = 0 after 1 cycle.
- out_ready held 0 for 4 cycles after an ADDI -> out stable, in_ready = 0; on release, the next ADDI appears the following cycle with no loss or duplication.
- reset = 0 asserted in DATA state mid-LD -> dreq_valid, out_valid and state clear immediately; a late data_ok after release has no effect; the next ADDI completes normally.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: pipeline bundles, data-bus structs, FSM state and bus constants.
package memory_stage_pkg;

    typedef enum logic [2:0] {
        OpAlu,
        OpLoad,
        OpStore,
        OpBranch,
        OpJump
    } decode_op_t;

    typedef struct packed {
        decode_op_t  op;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        jump;
        logic [4:0]  dst;
    } control_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
        logic [63:0] j_addr;
        logic [63:0] memdata;
        logic [63:0] result;
        control_t    ctl;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
        decode_op_t  op;
        logic        jump;
        logic        regwrite;
        logic [4:0]  dst;
        logic [63:0] regdata;
        logic [63:0] address;
        logic        skip;
    } memory_data_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } mem_state_t;

    localparam logic [2:0] MSIZE8    = 3'b011;
    localparam logic [7:0] STROBE_RD = 8'h00;
    localparam logic [7:0] STROBE_WR = 8'hFF;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Bundle copy for an op that does not touch the bus: result goes straight to regdata.
    function automatic memory_data_t pass_through(execute_data_t e);
        memory_data_t m;
        m             = '0;
        m.pc          = e.pc;
        m.instruction = e.instruction;
        m.op          = e.ctl.op;
        m.jump        = e.ctl.jump;
        m.regwrite    = e.ctl.regwrite;
        m.dst         = e.ctl.dst;
        m.regdata     = e.result;
        return m;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Two-phase data bus: address phase (dreq_valid/addr_ok) then data phase (data_ok).
interface memory_stage_if;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/memory_stage_dbus_ctrl.sv
// Data-bus transaction controller: holds the request, tracks address/data phases, flags completion.
module dbus_ctrl
    import memory_stage_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    input  logic [63:0]    addr_i,
    input  logic [63:0]    data_i,
    input  logic           write_i,
    output logic           idle_o,
    output logic           done_o,
    output logic [63:0]    rdata_o,
    memory_stage_if.master dbus
);

    mem_state_t state_q, state_d;
    dbus_req_t  req_q, req_d;
    dbus_resp_t resp;

    assign resp = '{addr_ok: dbus.dresp_addr_ok,
                    data_ok: dbus.dresp_data_ok,
                    data:    dbus.dresp_data};

    // Next state, request hold and completion; data_ok before addr_ok is ignored in ADDR.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    req_d.valid  = 1'b1;
                    req_d.addr   = addr_i;
                    req_d.size   = MSIZE8;
                    req_d.strobe = write_i ? STROBE_WR : STROBE_RD;
                    req_d.data   = data_i;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (resp.addr_ok) begin
                    req_d.valid = 1'b0;
                    if (resp.data_ok) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (resp.data_ok) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d.valid = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign idle_o           = (state_q == IDLE);
    assign rdata_o          = resp.data;
    assign dbus.dreq_valid  = req_q.valid;
    assign dbus.dreq_addr   = req_q.addr;
    assign dbus.dreq_size   = req_q.size;
    assign dbus.dreq_strobe = req_q.strobe;
    assign dbus.dreq_data   = req_q.data;

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the RV64 pipeline: routes LD/SD to the data bus, passes other ops through,
// and registers the writeback bundle with valid/ready backpressure.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned MMIO_BIT    = 31,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  execute_data_t  in,
    output logic           in_ready,
    output logic           out_valid,
    output memory_data_t   out,
    input  logic           out_ready,
    output logic           misalign,
    memory_stage_if.master dbus
);

    memory_data_t  out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          misalign_q, misalign_d;
    execute_data_t hold_q, hold_d;

    logic        bus_idle;
    logic        bus_done;
    logic [63:0] bus_rdata;
    logic        accept;
    logic        is_mem;
    logic        misaligned;
    logic        start;

    assign in_ready   = bus_idle && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_mem     = in.ctl.memread || in.ctl.memwrite;
    assign misaligned = ALIGN_CHECK && is_mem && (in.result[2:0] != 3'b000);
    assign start      = accept && is_mem && !misaligned;

    dbus_ctrl u_dbus_ctrl (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .addr_i  (in.result),
        .data_i  (in.memdata),
        .write_i (in.ctl.memwrite),
        .idle_o  (bus_idle),
        .done_o  (bus_done),
        .rdata_o (bus_rdata),
        .dbus    (dbus)
    );

    // Output bundle mux: direct ops load on accept, bus ops load at completion.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        hold_d      = hold_q;
        misalign_d  = 1'b0;
        if (start) begin
            hold_d = in;
        end
        if (accept && !start) begin
            out_d          = pass_through(in);
            // A suppressed misaligned op must not write back.
            out_d.regwrite = in.ctl.regwrite && !misaligned;
            out_valid_d    = 1'b1;
            misalign_d     = misaligned;
        end else if (bus_done) begin
            out_d          = pass_through(hold_q);
            out_d.regdata  = hold_q.ctl.memread ? bus_rdata : 64'h0;
            out_d.regwrite = hold_q.ctl.regwrite && hold_q.ctl.memread;
            out_d.address  = hold_q.result;
            out_d.skip     = ~hold_q.result[MMIO_BIT];
            out_valid_d    = 1'b1;
        end
    end

    // Output, misalign pulse and holding registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            hold_q      <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            misalign_q  <= misalign_d;
            hold_q      <= hold_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign misalign  = misalign_q;

    logic unused_fields;
    assign unused_fields = ^{in.j_addr, hold_q.j_addr, hold_q.memdata, hold_q.ctl.memwrite};

endmodule
